wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writer side of the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg).
- Merges two result sources onto that port:
  - the in-order pipeline writeback stage, which has no backpressure;
  - the multi-cycle multdiv unit, which uses a valid/ready handshake and is buffered in a small FIFO.
- Exports a pending-register mask for hazard/stall logic.
- Exports a stall request that prevents multdiv starvation.

Parameters:
- FIFO_DEPTH, 4, multdiv result FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may be blocked by pipeline writes before pipe_stall asserts.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- ctrl_reset  in  1  asynchronous, active-low reset.
- pipe_we  in  1  pipeline writeback valid.
- pipe_reg  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result.
- md_valid  in  1  multdiv result valid.
- md_reg  in  5  multdiv destination register.
- md_data  in  32  multdiv result.
- md_ready  out  1  FIFO can accept a result.
- ctrl_writeEnable  out  1  register-file write enable, registered.
- ctrl_writeReg  out  5  register-file write address, registered.
- data_writeReg  out  32  register-file write data, registered.
- pending_mask  out  32  bit r = 1 while any FIFO entry targets register r.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- pipe_stall  out  1  request to insert a pipeline bubble, registered.

Behaviour:
- Reset (ctrl_reset = 0, asynchronous assert, synchronous release):
  - FIFO emptied; all queued entries discarded.
  - ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0.
  - pending_mask = 0, fifo_count = 0, pipe_stall = 0, starve counter = 0.
  - md_ready = 0 only while reset is asserted.
  - Reset mid-operation: any write in flight is dropped; ctrl_writeEnable falls immediately.
- Handshake:
  - md_ready = (fifo_count < FIFO_DEPTH); derived from registered count only.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Push on md_valid & md_ready.
  - md_valid with md_reg = 0: the handshake completes, but nothing is enqueued.
  - md_valid while full is legal; the source holds md_reg and md_data stable until accepted.
- Per-cycle arbitration (result registered onto the write outputs at the next edge, so latency = 1 cycle):
  - (1) pipe_we & pipe_reg != 0 → issue the pipeline write. The FIFO does not pop.
  - (2) else if FIFO not empty → issue the head entry and pop.
  - (3) else → ctrl_writeEnable = 0. ctrl_writeReg and data_writeReg hold their previous values.
  - pipe_we with pipe_reg = 0 counts as no pipeline request, so the FIFO may issue that cycle.
- FIFO timing and ordering:
  - An entry pushed in cycle N can be issued no earlier than the decision in cycle N+1.
  - Minimum multdiv-to-port latency is therefore 2 edges.
  - No bypass path exists.
  - Order is strictly FIFO. Multiple entries may target the same register; the last one issued wins.
- pending_mask:
  - Combinational OR of one-hot decodes of all valid entries' registers.
  - A bit clears in the cycle after its last entry pops.
  - Stall logic uses it to block WAW/RAW hazards on those registers.
  - If a pipeline write to register r occurs while r is pending anyway, it still issues first; the queued entry overwrites it later.
- Counters and wrap-around:
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count = pushes − pops and never exceeds FIFO_DEPTH.
  - A simultaneous push and pop leaves fifo_count unchanged.
- Starvation:
  - The starve counter increments on each cycle where the FIFO is non-empty and the pipeline wins.
  - It resets to 0 on any FIFO pop or when the FIFO is empty.
  - pipe_stall is set at the edge where the counter reaches STARVE_LIMIT.
  - pipe_stall is cleared at the edge after the next FIFO pop.
  - The counter saturates at STARVE_LIMIT.

Test Plan:
- Reset check: pulse ctrl_reset = 0 mid-run with 3 FIFO entries queued → ctrl_writeEnable drops immediately; after release, fifo_count = 0, pending_mask = 0, no stale writes are issued.
- Pipeline only: pipe_we = 1, pipe_reg = 5, pipe_data = 0xDEADBEEF at cycle 0 → cycle 1 shows ctrl_writeEnable = 1, ctrl_writeReg = 5, data_writeReg = 0xDEADBEEF. Then pipe_reg = 0 → no write.
- Multdiv only:
  - Push reg 7 = 0x12 at cycle 0 → pending_mask = 0x80 at cycle 1; the write appears at cycle 2; pending_mask = 0 at cycle 3.
  - md_reg = 0 → handshake completes and fifo_count stays 0.
- Collision: md pushes to regs 3, 4 plus pipe_we every cycle to reg 9 for 3 cycles → port sequence 9, 9, 9, 3, 4; fifo_count peaks at 2.
- Full FIFO: 5 back-to-back md_valid with pipe_we held high → md_ready = 0 after 4 accepts; the 5th is held and accepted only after the first pop.
- Starvation: 1 queued entry, pipe_we high for 10 cycles → pipe_stall asserts after 8 blocked cycles. Drop pipe_we → entry issues and pipe_stall clears on the following edge.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// wb_arbiter : merges pipeline writeback and queued multdiv results onto the
//              register file's single write port.  Rev 1.0
// ============================================================================
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clock,
  input  logic                          ctrl_reset,
  input  logic                          pipe_we,
  input  logic [4:0]                    pipe_reg,
  input  logic [31:0]                   pipe_data,
  input  logic                          md_valid,
  input  logic [4:0]                    md_reg,
  input  logic [31:0]                   md_data,
  output logic                          md_ready,
  output logic                          ctrl_writeEnable,
  output logic [4:0]                    ctrl_writeReg,
  output logic [31:0]                   data_writeReg,
  output logic [31:0]                   pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          pipe_stall
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            fifo_reg  [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt;
  logic [SW-1:0]         starve_nxt;
  logic                  pop_q;

  logic pipe_req;
  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_empty = (count == '0);
  assign md_ready   = ctrl_reset && (count < CW'(FIFO_DEPTH));
  assign pipe_req   = pipe_we && (pipe_reg != 5'd0);
  // A zero destination completes the handshake but is never stored.
  assign push       = md_valid && md_ready && (md_reg != 5'd0);
  assign pop        = !pipe_req && !fifo_empty;
  assign fifo_count = count;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld[i]) pending_mask[fifo_reg[i]] = 1'b1;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (fifo_empty || pop)
      starve_nxt = '0;
    else if (pipe_req && (starve_cnt != SW'(STARVE_LIMIT)))
      starve_nxt = starve_cnt + SW'(1);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= md_reg;
      fifo_data[wr_ptr] <= md_data;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      fifo_vld         <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      starve_cnt       <= '0;
      pop_q            <= 1'b0;
      pipe_stall       <= 1'b0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
    end else begin
      // Push and pop never share a slot: equal pointers mean empty or full.
      if (push) begin
        fifo_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (pipe_req) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= pipe_reg;
        data_writeReg    <= pipe_data;
      end else if (pop) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= fifo_reg[rd_ptr];
        data_writeReg    <= fifo_data[rd_ptr];
      end else begin
        ctrl_writeEnable <= 1'b0;
      end

      starve_cnt <= starve_nxt;
      pop_q      <= pop;
      // Stall drops one edge after the starved entry finally drains.
      if (starve_nxt == SW'(STARVE_LIMIT))
        pipe_stall <= 1'b1;
      else if (pop_q)
        pipe_stall <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_arbiter : randomized + directed bench with a queue-based reference.
// Rev 1.0
// ============================================================================
module tb_wb_arbiter;

  localparam int D = 4;
  localparam int L = 8;

  logic        clock      = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        pipe_we    = 1'b0;
  logic [4:0]  pipe_reg   = '0;
  logic [31:0] pipe_data  = '0;
  logic        md_valid   = 1'b0;
  logic [4:0]  md_reg     = '0;
  logic [31:0] md_data    = '0;
  logic        md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
  logic        pipe_stall;

  always #5 clock = ~clock;

  wb_arbiter #(.FIFO_DEPTH(D), .STARVE_LIMIT(L)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .pending_mask(pending_mask),
    .fifo_count(fifo_count), .pipe_stall(pipe_stall)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_we     = 1'b0;
  logic [4:0]  m_reg    = '0;
  logic [31:0] m_data   = '0;
  int          m_starve = 0;
  logic        m_stall  = 1'b0;
  logic        m_ppop   = 1'b0;
  logic        m_acc    = 1'b0;

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) m[q[i].r] = 1'b1;
    return m;
  endfunction

  // Reference model update plus per-cycle comparison.
  always @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      q.delete();
      m_we = 1'b0; m_reg = '0; m_data = '0;
      m_starve = 0; m_stall = 1'b0; m_ppop = 1'b0; m_acc = 1'b0;
    end else begin
      int   sz;
      logic preq, pop;
      ent_t e;
      sz    = q.size();
      m_acc = md_valid && (sz < D);
      preq  = pipe_we && (pipe_reg != 5'd0);
      pop   = !preq && (sz > 0);
      if (preq) begin
        m_we = 1'b1; m_reg = pipe_reg; m_data = pipe_data;
      end else if (pop) begin
        e = q.pop_front();
        m_we = 1'b1; m_reg = e.r; m_data = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (m_acc && md_reg != 5'd0) q.push_back('{r: md_reg, d: md_data});
      if (sz == 0 || pop) m_starve = 0;
      else if (preq && m_starve < L) m_starve++;
      if (m_ppop) m_stall = 1'b0;
      if (m_starve == L) m_stall = 1'b1;
      m_ppop = pop;
    end
    #1;
    chk("we",      {31'd0, ctrl_writeEnable}, {31'd0, m_we});
    chk("wreg",    {27'd0, ctrl_writeReg},    {27'd0, m_reg});
    chk("wdata",   data_writeReg,             m_data);
    chk("mask",    pending_mask,              model_mask());
    chk("count",   {29'd0, fifo_count},       32'(q.size()));
    chk("ready",   {31'd0, md_ready},         {31'd0, ctrl_reset && (q.size() < D)});
    chk("stall",   {31'd0, pipe_stall},       {31'd0, m_stall});
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_pipe(input logic we, input logic [4:0] r, input logic [31:0] d);
    pipe_we = we; pipe_reg = r; pipe_data = d;
  endtask

  task automatic set_md(input logic v, input logic [4:0] r, input logic [31:0] d);
    md_valid = v; md_reg = r; md_data = d;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_we",    {31'd0, ctrl_writeEnable}, 32'd0);
    chk("rst_ready", {31'd0, md_ready},         32'd0);
    chk("rst_count", {29'd0, fifo_count},       32'd0);
    ctrl_reset = 1'b1;
    tick();

    // Pipeline only
    set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("pipe_we",   {31'd0, ctrl_writeEnable}, 32'd1);
    chk("pipe_reg",  {27'd0, ctrl_writeReg},    32'd5);
    chk("pipe_data", data_writeReg,             32'hDEADBEEF);
    set_pipe(1'b1, 5'd0, 32'h1);
    tick();
    chk("pipe_r0_we",  {31'd0, ctrl_writeEnable}, 32'd0);
    chk("pipe_r0_reg", {27'd0, ctrl_writeReg},    32'd5);
    set_pipe(1'b0, 5'd0, 32'd0);

    // Multdiv only
    set_md(1'b1, 5'd7, 32'h12);
    tick();
    set_md(1'b0, 5'd0, 32'd0);
    chk("md_mask1", pending_mask, 32'h80);
    chk("md_we1",   {31'd0, ctrl_writeEnable}, 32'd0);
    tick();
    chk("md_we2",   {31'd0, ctrl_writeEnable}, 32'd1);
    chk("md_reg2",  {27'd0, ctrl_writeReg},    32'd7);
    chk("md_data2", data_writeReg,             32'h12);
    tick();
    chk("md_mask3", pending_mask, 32'h0);
    set_md(1'b1, 5'd0, 32'h55);
    chk("md_r0_ready", {31'd0, md_ready}, 32'd1);
    tick();
    chk("md_r0_acc",   {31'd0, m_acc},      32'd1);
    chk("md_r0_count", {29'd0, fifo_count}, 32'd0);
    set_md(1'b0, 5'd0, 32'd0);
    tick();

    // Collision: port sequence 9,9,9,3,4
    set_pipe(1'b1, 5'd9, 32'h900);
    set_md(1'b1, 5'd3, 32'h300);
    tick();
    chk("col_r1", {27'd0, ctrl_writeReg}, 32'd9);
    set_md(1'b1, 5'd4, 32'h400);
    tick();
    chk("col_r2", {27'd0, ctrl_writeReg}, 32'd9);
    chk("col_peak", {29'd0, fifo_count}, 32'd2);
    set_md(1'b0, 5'd0, 32'd0);
    tick();
    chk("col_r3", {27'd0, ctrl_writeReg}, 32'd9);
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    chk("col_r4", {27'd0, ctrl_writeReg}, 32'd3);
    chk("col_d4", data_writeReg, 32'h300);
    tick();
    chk("col_r5", {27'd0, ctrl_writeReg}, 32'd4);
    chk("col_c5", {29'd0, fifo_count}, 32'd0);

    // Full FIFO
    set_pipe(1'b1, 5'd9, 32'h900);
    for (int k = 0; k < 4; k++) begin
      set_md(1'b1, 5'(10 + k), 32'(256 + k));
      tick();
    end
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_ready", {31'd0, md_ready},   32'd0);
    set_md(1'b1, 5'd14, 32'h104);
    tick();
    chk("full_hold", {29'd0, fifo_count}, 32'd4);
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    chk("full_pop1", {27'd0, ctrl_writeReg}, 32'd10);
    chk("full_c1",   {29'd0, fifo_count},    32'd3);
    chk("full_rdy1", {31'd0, md_ready},      32'd1);
    tick();
    chk("full_pop2", {27'd0, ctrl_writeReg}, 32'd11);
    chk("full_c2",   {29'd0, fifo_count},    32'd3);
    set_md(1'b0, 5'd0, 32'd0);
    repeat (3) tick();
    chk("full_last", {27'd0, ctrl_writeReg}, 32'd14);
    chk("full_ldat", data_writeReg,          32'h104);

    // Starvation
    set_md(1'b1, 5'd20, 32'hABC);
    tick();
    set_md(1'b0, 5'd0, 32'd0);
    set_pipe(1'b1, 5'd9, 32'h900);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) chk("starve7", {31'd0, pipe_stall}, 32'd0);
      if (i == 8) chk("starve8", {31'd0, pipe_stall}, 32'd1);
    end
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    chk("starve_issue", {27'd0, ctrl_writeReg}, 32'd20);
    chk("starve_held",  {31'd0, pipe_stall},    32'd1);
    tick();
    chk("starve_clr",   {31'd0, pipe_stall},    32'd0);

    // Reset mid-operation with 3 entries queued
    set_pipe(1'b1, 5'd9, 32'h900);
    for (int k = 0; k < 3; k++) begin
      set_md(1'b1, 5'(1 + k), 32'(k));
      tick();
    end
    set_md(1'b0, 5'd0, 32'd0);
    chk("mrst_pre", {29'd0, fifo_count}, 32'd3);
    #1 ctrl_reset = 1'b0;
    #2;
    chk("mrst_we",    {31'd0, ctrl_writeEnable}, 32'd0);
    chk("mrst_count", {29'd0, fifo_count},       32'd0);
    chk("mrst_mask",  pending_mask,              32'd0);
    tick();
    ctrl_reset = 1'b1;
    set_pipe(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mrst_stale", {31'd0, ctrl_writeEnable}, 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int heavy;
      heavy = ((n / 64) % 3 == 1) ? 1 : 0;
      if (!(md_valid && !m_acc)) begin
        set_md(($urandom % 3) == 0, 5'($urandom % 8), $urandom);
      end
      if (heavy != 0) set_pipe(($urandom % 16) != 0, 5'(1 + $urandom % 5), $urandom);
      else            set_pipe(($urandom % 3) == 0,  5'($urandom % 6),     $urandom);
      if (($urandom % 500) == 0) begin
        ctrl_reset = 1'b0;
        tick();
        ctrl_reset = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
